// File: rtl/morse_key_decoder_if.sv
// Letter-side bundle of the Morse key decoder: raw key line in, decoded letter
// index with valid/error pulses and a busy flag out.
interface morse_key_decoder_if;
   logic       key_i;
   logic [4:0] letter_o;
   logic       valid_o;
   logic       error_o;
   logic       busy_o;

   // master = decoder side, slave = key source / letter consumer side
   modport master (
      input  key_i,
      output letter_o,
      output valid_o,
      output error_o,
      output busy_o
   );

   modport slave (
      output key_i,
      input  letter_o,
      input  valid_o,
      input  error_o,
      input  busy_o
   );
endinterface

// File: rtl/morse_key_decoder.sv
// Morse receiver: times marks/spaces on a synchronised key line, collects up to
// four dot/dash symbols and decodes each character to letter index A=0..Z=25.
// Optional MORSE_GLITCH_FILTER_EN drops marks shorter than half a time unit.
module morse_key_decoder #(
   parameter int UNIT_CYCLES = 4,
   parameter int CNT_W       = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   morse_key_decoder_if.master   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MARK  = 2'd1,
      SPACE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] DASH_MIN = CNT_W'(2 * UNIT_CYCLES);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(3 * UNIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             key_meta_reg;
   logic             k_s_reg;
   logic [3:0]       pat_reg;
   logic [2:0]       len_reg;
   logic             ovf_reg;
   logic [4:0]       letter_reg;
   logic             valid_reg;
   logic             error_reg;
   logic             busy_reg;

   logic             is_dash;
   logic             glitch_mark;
   logic [25:0]      match;
   logic             match_any;
   logic [4:0]       match_idx;

   // {len, pat} for each letter; pat holds the symbols right-aligned, dash = 1
   function automatic logic [6:0] code_of(input int idx);
      logic [6:0] code;
      case (idx)
         0:  code = 7'b010_0001;
         1:  code = 7'b100_1000;
         2:  code = 7'b100_1010;
         3:  code = 7'b011_0100;
         4:  code = 7'b001_0000;
         5:  code = 7'b100_0010;
         6:  code = 7'b011_0110;
         7:  code = 7'b100_0000;
         8:  code = 7'b010_0000;
         9:  code = 7'b100_0111;
         10: code = 7'b011_0101;
         11: code = 7'b100_0100;
         12: code = 7'b010_0011;
         13: code = 7'b010_0010;
         14: code = 7'b011_0111;
         15: code = 7'b100_0110;
         16: code = 7'b100_1101;
         17: code = 7'b011_0010;
         18: code = 7'b011_0000;
         19: code = 7'b001_0001;
         20: code = 7'b011_0001;
         21: code = 7'b100_0001;
         22: code = 7'b011_0011;
         23: code = 7'b100_1001;
         24: code = 7'b100_1011;
         25: code = 7'b100_1100;
         default: code = 7'b000_0000;
      endcase
      return code;
   endfunction

   generate
      for (genvar gi = 0; gi < 26; gi++) begin : g_match
         assign match[gi] = ({len_reg, pat_reg} == code_of(gi));
      end
   endgenerate

   always_comb begin
      match_any = 1'b0;
      match_idx = 5'd0;
      for (int i = 0; i < 26; i++) begin
         if (match[i]) begin
            match_any = 1'b1;
            match_idx = 5'(i);
         end
      end
   end

   assign is_dash = (cnt_reg >= DASH_MIN);

`ifdef MORSE_GLITCH_FILTER_EN
   localparam logic [CNT_W-1:0] GLITCH_MIN =
      CNT_W'((UNIT_CYCLES / 2 < 1) ? 1 : UNIT_CYCLES / 2);
   assign glitch_mark = (cnt_reg < GLITCH_MIN);
`else
   assign glitch_mark = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         key_meta_reg <= 1'b0;
         k_s_reg      <= 1'b0;
         pat_reg      <= '0;
         len_reg      <= '0;
         ovf_reg      <= 1'b0;
         letter_reg   <= '0;
         valid_reg    <= 1'b0;
         error_reg    <= 1'b0;
         busy_reg     <= 1'b0;
      end else begin
         key_meta_reg <= bus.key_i;
         k_s_reg      <= key_meta_reg;
         valid_reg    <= 1'b0;
         error_reg    <= 1'b0;

         case (state_reg)
            IDLE: begin
               cnt_reg <= '0;
               if (k_s_reg) begin
                  state_reg <= MARK;
                  cnt_reg   <= CNT_ONE;
                  busy_reg  <= 1'b1;
               end
            end

            MARK: begin
               if (k_s_reg) begin
                  if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + CNT_ONE;
               end else if (glitch_mark && (len_reg == 3'd0)) begin
                  state_reg <= IDLE;
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b0;
               end else begin
                  // this low sample is the first of the following space
                  state_reg <= SPACE;
                  cnt_reg   <= CNT_ONE;
                  if (!glitch_mark) begin
                     if (len_reg < 3'd4) begin
                        pat_reg <= {pat_reg[2:0], is_dash};
                        len_reg <= len_reg + 3'd1;
                     end else begin
                        ovf_reg <= 1'b1;
                     end
                  end
               end
            end

            SPACE: begin
               if (k_s_reg) begin
                  state_reg <= MARK;
                  cnt_reg   <= CNT_ONE;
               end else if (cnt_reg == GAP_LAST) begin
                  if (match_any && !ovf_reg) begin
                     letter_reg <= match_idx;
                     valid_reg  <= 1'b1;
                  end else begin
                     error_reg  <= 1'b1;
                  end
                  state_reg <= IDLE;
                  cnt_reg   <= '0;
                  pat_reg   <= '0;
                  len_reg   <= '0;
                  ovf_reg   <= 1'b0;
                  busy_reg  <= 1'b0;
               end else begin
                  cnt_reg <= cnt_reg + CNT_ONE;
               end
            end

            default: begin
               state_reg <= IDLE;
               cnt_reg   <= '0;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.letter_o = letter_reg;
   assign bus.valid_o  = valid_reg;
   assign bus.error_o  = error_reg;
   assign bus.busy_o   = busy_reg;

endmodule

// File: tb/tb_morse_key_decoder.sv
// Scoreboard bench for morse_key_decoder: directed and random characters are
// turned into expected letters/errors by a string-level Morse model.
module tb_morse_key_decoder;
   localparam int U = 4;

   logic clk;
   logic rst;

   morse_key_decoder_if bus ();

   morse_key_decoder #(
      .UNIT_CYCLES(U),
      .CNT_W      (16)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit       err;
      int       letter;
   } exp_t;

   exp_t  exp_q[$];
   int    cur_marks[$];
   int    cur_gaps[$];
   int    exp_last;
   int    checks;
   int    errors;

   string MORSE [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                         "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                         "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                         "-.--", "--.."};

   function automatic int glitch_min();
`ifdef MORSE_GLITCH_FILTER_EN
      return (U / 2 < 1) ? 1 : U / 2;
`else
      return 1;
`endif
   endfunction

   function automatic void push_expect(input string s);
      exp_t e;
      e.err    = 1'b1;
      e.letter = 0;
      if (s.len() <= 4) begin
         for (int k = 0; k < 26; k++) begin
            if (MORSE[k] == s) begin
               e.err    = 1'b0;
               e.letter = k;
            end
         end
      end
      exp_q.push_back(e);
   endfunction

   // Reference: classify each mark by duration, split characters at gaps >= 3 units
   function automatic void model_push();
      string syms;
      syms = "";
      for (int i = 0; i < cur_marks.size(); i++) begin
         if (cur_marks[i] >= glitch_min()) begin
            if (cur_marks[i] < 2 * U) syms = {syms, "."};
            else                      syms = {syms, "-"};
         end
         if (cur_gaps[i] >= 3 * U) begin
            if (syms.len() > 0) push_expect(syms);
            syms = "";
         end
      end
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic add(input int mk, input int gp);
      cur_marks.push_back(mk);
      cur_gaps.push_back(gp);
   endtask

   task automatic transmit();
      for (int i = 0; i < cur_marks.size(); i++) begin
         bus.key_i = 1'b1;
         repeat (cur_marks[i]) @(negedge clk);
         if (cur_marks[i] >= 3) chk("busy_in_mark", int'(bus.busy_o), 1);
         bus.key_i = 1'b0;
         repeat (cur_gaps[i]) @(negedge clk);
      end
      cur_marks.delete();
      cur_gaps.delete();
   endtask

   task automatic flush();
      model_push();
      transmit();
   endtask

   task automatic random_char();
      string s;
      s = "";
      if ($urandom_range(0, 4) == 0) begin
         int n = $urandom_range(1, 5);
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 1) == 1) s = {s, "-"};
            else                           s = {s, "."};
         end
      end else begin
         s = MORSE[$urandom_range(0, 25)];
      end
      for (int k = 0; k < s.len(); k++) begin
         int mk;
         int gp;
         if (s.getc(k) == 8'd45) mk = $urandom_range(2 * U, 3 * U + 6);
         else                    mk = $urandom_range(1, 2 * U - 1);
         if (k == s.len() - 1) gp = $urandom_range(3 * U, 3 * U + 5);
         else                  gp = $urandom_range(1, 3 * U - 1);
         add(mk, gp);
      end
      flush();
   endtask

   // Monitor: every pulse must match the head of the expectation queue
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && (bus.valid_o || bus.error_o)) begin
            checks++;
            if (bus.valid_o && bus.error_o) begin
               errors++;
               $display("FAIL valid_and_error actual=both required=one");
            end else if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pulse actual=valid%0d/error%0d letter=%0d required=none",
                        bus.valid_o, bus.error_o, bus.letter_o);
            end else begin
               e = exp_q.pop_front();
               if (e.err) begin
                  if (!bus.error_o || int'(bus.letter_o) != exp_last) begin
                     errors++;
                     $display("FAIL error_pulse actual=valid%0d/error%0d letter=%0d required=error letter=%0d",
                              bus.valid_o, bus.error_o, bus.letter_o, exp_last);
                  end
               end else begin
                  if (!bus.valid_o || int'(bus.letter_o) != e.letter) begin
                     errors++;
                     $display("FAIL letter_pulse actual=valid%0d/error%0d letter=%0d required=valid letter=%0d",
                              bus.valid_o, bus.error_o, bus.letter_o, e.letter);
                  end
                  exp_last = e.letter;
               end
            end
         end
      end
   end

   initial begin
      int t;
      checks   = 0;
      errors   = 0;
      exp_last = 0;
      rst      = 1'b1;
      bus.key_i = 1'b0;

      // reset with key toggling
      for (int i = 0; i < 8; i++) begin
         bus.key_i = ~bus.key_i;
         @(negedge clk);
         chk("rst_letter", int'(bus.letter_o), 0);
         chk("rst_valid",  int'(bus.valid_o),  0);
         chk("rst_error",  int'(bus.error_o),  0);
         chk("rst_busy",   int'(bus.busy_o),   0);
      end
      bus.key_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("post_rst_busy",   int'(bus.busy_o),   0);
      chk("post_rst_letter", int'(bus.letter_o), 0);

      // A, B, Z
      add(4, 4);  add(12, 12); flush();
      add(12, 4); add(4, 4);   add(4, 4);  add(4, 12); flush();
      add(12, 4); add(12, 4);  add(4, 4);  add(4, 12); flush();
      // dot/dash boundary: E then T
      add(7, 12); flush();
      add(8, 12); flush();
      // gap boundary: I, then E, E
      add(4, 11); add(4, 12); flush();
      add(4, 12); add(4, 12); flush();
      // errors after T
      add(12, 12); flush();
      add(4, 4); add(4, 4); add(12, 4); add(12, 12); flush();
      add(4, 4); add(4, 4); add(4, 4); add(4, 4); add(4, 12); flush();
      repeat (20) @(negedge clk);
      chk("letter_after_errors", int'(bus.letter_o), 19);

      // reset mid-character discards the partial "-."
      add(12, 4); add(4, 2); transmit();
      rst = 1'b1;
      exp_last = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy",   int'(bus.busy_o),   0);
      chk("midrst_letter", int'(bus.letter_o), 0);
      repeat (20) @(negedge clk);
      add(4, 12); flush();

`ifdef MORSE_GLITCH_FILTER_EN
      add(4, 4); add(1, 4); add(4, 12); flush();
`endif

      for (int n = 0; n < 40; n++) random_char();

      // idle line: nothing further may appear
      bus.key_i = 1'b0;
      t = 0;
      while (exp_q.size() > 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("pending_expectations", exp_q.size(), 0);
      repeat (60) @(negedge clk);
      chk("final_busy", int'(bus.busy_o), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/morse_key_decoder.md
Name: morse_key_decoder

Overview:
Morse receiver. It times the on/off key line, builds dot/dash symbol sequences, and decodes each completed character to the same 5-bit letter index (A=0 … Z=25) used by the seven-segment letter display. It sits between the external key pin and the display path. It emits one valid pulse per decoded letter, or one error pulse per undecodable character.

Parameters:
UNIT_CYCLES, 4, clock cycles per Morse time unit (dot length); legal range 2..4096
CNT_W, 16, width of the mark/space duration counter; saturating; must hold 3*UNIT_CYCLES

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous, active-high reset
key_i  input  1  raw key line, 1 = tone/mark, 0 = space; asynchronous to clk_i
letter_o  output  5  last successfully decoded letter index, 0..25
valid_o  output  1  one-cycle pulse: letter_o updated this cycle
error_o  output  1  one-cycle pulse: completed character was not A–Z
busy_o  output  1  high while a character is in progress (state != IDLE)

Behaviour:
- Reset and clock: one clock; reset is asynchronous and active-high.
  - On rst_i: all flops clear, FSM = IDLE.
  - letter_o=0, valid_o=0, error_o=0, busy_o=0.
  - Reset mid-character discards the partial symbols; no pulse is produced.
- Input synchroniser: key_i passes through a 2-flop synchroniser (k_s). All timing below refers to k_s.
- Symbol store:
  - pat[3:0]: shifted left on each symbol, new symbol in the LSB (dot=0, dash=1).
  - len[2:0]: symbols captured.
  - ovf: set when a 5th symbol arrives.
- FSM states and transitions:
  - IDLE: cnt=0. k_s=1 → MARK with cnt=1.
  - MARK: cnt increments per cycle of k_s=1, saturating at all-ones. On k_s=0, classify the mark:
    - H = cnt, the number of high cycles.
    - dot if H < 2*UNIT_CYCLES, else dash.
    - If len<4, append the symbol and len++; else set ovf.
    - Go to SPACE with cnt=1.
  - SPACE: cnt increments per cycle of k_s=0.
    - k_s=1 while cnt < 3*UNIT_CYCLES → MARK with cnt=1 (intra-character gap).
    - cnt reaching 3*UNIT_CYCLES with k_s=0 → character complete: decode, then go to IDLE and clear pat/len/ovf.
    - Completion and a rising key on the same cycle are impossible by construction. The 3*UNIT_CYCLES-th low sample completes the character; a later rise starts a new character from IDLE.
- Decode (registered):
  - Standard ITU Morse for A–Z, lengths 1..4. Examples: (len=2,pat=01)→0 "A", (4,1000)→1 "B", (1,0)→4 "E", (1,1)→19 "T", (4,1100)→25 "Z".
  - On a match: letter_o ← index and valid_o=1 for exactly one cycle, the cycle after completion.
  - On no match or ovf: error_o=1 for one cycle and letter_o is unchanged.
  - valid_o and error_o are never high together.
- Latency: from the final low sample at k_s to valid_o/error_o is 1 cycle. From the raw key_i falling edge it is 2 + 3*UNIT_CYCLES + 1 cycles.
- Idle line: key held low forever → no pulses. Key held high forever → cnt saturates, busy_o=1, and on release the symbol is a dash.

Optional Feature:
MORSE_GLITCH_FILTER_EN
- Defined: any mark with H < UNIT_CYCLES/2 (integer division, minimum 1) is discarded; no symbol is appended.
  - If len==0, return to IDLE.
  - Otherwise return to SPACE with cnt=1, restarting the gap timing.
- Not defined: every mark of H ≥ 1 cycle is a symbol (a 1-cycle mark is a dot).

Test Plan (all with UNIT_CYCLES=4):
1. Reset: assert rst_i while key_i toggles → letter_o=0, valid_o=0, error_o=0, busy_o=0 throughout. Release → still all 0 with key_i=0.
2. ".-": mark 4, space 4, mark 12, space 12 → exactly one valid_o pulse with letter_o=0. Then "-...", then "--.." back-to-back (12-cycle gaps) → pulses with letter_o=1, then 25.
3. Classification boundary:
   - mark 7 then space 12 → letter_o=4 (E).
   - mark 8 then space 12 → letter_o=19 (T).
4. Gap boundary:
   - dot, space 11, dot, space 12 → single valid with letter_o=8 (I).
   - dot, space 12, dot, space 12 → two valid pulses, letter_o=4 each.
5. Errors (after first decoding T so letter_o=19):
   - "..--" → one error_o pulse, no valid_o, letter_o stays 19.
   - five dots → one error_o pulse.
6. rst_i pulsed after "-." marks mid-character → no pulses, FSM back in IDLE. Then send "." → letter_o=4. With MORSE_GLITCH_FILTER_EN: a 1-cycle mark between two dots spaced 4 → decoded as "..", letter_o=8.
